// File: rtl/car_sim_pkg.sv
// Shared definitions for the car simulation lamp controllers: mode encoding,
// lamp bit positions and the blink-direction helper used for phase restarts.
package car_sim_pkg;

  localparam logic [2:0] MODE_OFF       = 3'd0;
  localparam logic [2:0] MODE_STEADY    = 3'd1;
  localparam logic [2:0] MODE_LEFT      = 3'd2;
  localparam logic [2:0] MODE_RIGHT     = 3'd3;
  localparam logic [2:0] MODE_HAZARD    = 3'd4;
  localparam logic [2:0] MODE_COMFORT_L = 3'd5;
  localparam logic [2:0] MODE_COMFORT_R = 3'd6;

  localparam int LED_L = 1;
  localparam int LED_R = 0;

  typedef enum logic [2:0] {
    S_OFF       = MODE_OFF,
    S_STEADY    = MODE_STEADY,
    S_LEFT      = MODE_LEFT,
    S_RIGHT     = MODE_RIGHT,
    S_HAZARD    = MODE_HAZARD,
    S_COMFORT_L = MODE_COMFORT_L,
    S_COMFORT_R = MODE_COMFORT_R
  } state_t;

  typedef enum logic [1:0] {
    DIR_NONE,
    DIR_LEFT,
    DIR_RIGHT,
    DIR_BOTH
  } dir_t;

  // Blink states sharing a direction share a phase; a direction change restarts it.
  function automatic dir_t dir_of(state_t s);
    case (s)
      S_LEFT, S_COMFORT_L:  return DIR_LEFT;
      S_RIGHT, S_COMFORT_R: return DIR_RIGHT;
      S_HAZARD:             return DIR_BOTH;
      default:              return DIR_NONE;
    endcase
  endfunction

endpackage

// File: rtl/turn_signal_seq_if.sv
// Lever/switch inputs and lamp/status outputs of the turn signal sequencer.
interface turn_signal_seq_if;
  logic       power;
  logic       left;
  logic       right;
  logic       hazard;
  logic [1:0] led;
  logic [2:0] mode;
  logic       comfort_done;

  modport master (
    output power, left, right, hazard,
    input  led, mode, comfort_done
  );

  modport slave (
    input  power, left, right, hazard,
    output led, mode, comfort_done
  );
endinterface

// File: rtl/blink_phase_gen.sv
// Wrapping blink phase counter; lit/restart look at the phase the next edge
// will load so a registered lamp lines up with the edge that starts a blink.
module blink_phase_gen #(
  parameter int PERIOD_CYC = 10_000_000,
  parameter int ON_CYC     = 5_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic restart,
  output logic lit,
  output logic wrap
);
  localparam int PW = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;

  logic [PW-1:0] phase_q;
  logic [PW-1:0] phase_d;

  // wrap flags the last cycle of a period; it reflects the current phase only
  assign wrap = (phase_q == PW'(PERIOD_CYC - 1));

  always_comb begin
    phase_d = '0;
    if (run && !restart && !wrap) phase_d = phase_q + 1'b1;
  end

  assign lit = run && (phase_d < PW'(ON_CYC));

  always_ff @(posedge clk) begin
    if (!rst_n) phase_q <= '0;
    else        phase_q <= phase_d;
  end
endmodule

// File: rtl/turn_signal_seq.sv
// Turn signal sequencer: steady, left/right, hazard and comfort (tap) blink
// modes driving the left/right indicator lamps.
//
// state       | meaning
// S_OFF       | ignition off, lamps dark
// S_STEADY    | running lights
// S_LEFT      | left lever held, left lamp blinks
// S_RIGHT     | right lever held, right lamp blinks
// S_HAZARD    | hazard switch on, both lamps blink in phase
// S_COMFORT_L | left tap released, finishing the fixed flash count
// S_COMFORT_R | right tap released, finishing the fixed flash count
module turn_signal_seq
  import car_sim_pkg::*;
#(
  parameter int PERIOD_CYC      = 10_000_000,
  parameter int ON_CYC          = 5_000_000,
  parameter int TAP_CYC         = 25_000_000,
  parameter int COMFORT_FLASHES = 3,
  parameter int STEADY_ON       = 1
) (
  input logic             clk,
  input logic             rst_n,
  turn_signal_seq_if.slave bus
);
  localparam int   HW         = $clog2(TAP_CYC + 1);
  localparam int   FW         = $clog2(COMFORT_FLASHES + 1);
  localparam logic STEADY_LIT = (STEADY_ON != 0);

  state_t        state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [FW-1:0] flash_q, flash_d;
  logic [1:0]    led_q, led_d;
  logic          done_q, done_d;
  logic          run, restart, lit, wrap;
  logic          lever_entry, in_signal;

  blink_phase_gen #(
    .PERIOD_CYC(PERIOD_CYC),
    .ON_CYC    (ON_CYC)
  ) u_phase (
    .clk    (clk),
    .rst_n  (rst_n),
    .run    (run),
    .restart(restart),
    .lit    (lit),
    .wrap   (wrap)
  );

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    if (!bus.power)                 state_d = S_OFF;
    else if (bus.hazard)            state_d = S_HAZARD;
    else if (bus.left && bus.right) state_d = S_STEADY;
    else if (bus.left)              state_d = S_LEFT;
    else if (bus.right)             state_d = S_RIGHT;
    else begin
      case (state_q)
        S_LEFT:  state_d = (hold_q < HW'(TAP_CYC)) ? S_COMFORT_L : S_STEADY;
        S_RIGHT: state_d = (hold_q < HW'(TAP_CYC)) ? S_COMFORT_R : S_STEADY;
        S_COMFORT_L, S_COMFORT_R: begin
          // >= also covers taps long enough to have wrapped past the count
          if (wrap && (flash_q >= FW'(COMFORT_FLASHES - 1))) begin
            state_d = S_STEADY;
            done_d  = 1'b1;
          end
        end
        default: state_d = S_STEADY;
      endcase
    end
  end

  assign run         = (dir_of(state_d) != DIR_NONE);
  assign restart     = run && (dir_of(state_d) != dir_of(state_q));
  assign lever_entry = ((state_d == S_LEFT) || (state_d == S_RIGHT)) && (state_d != state_q);
  assign in_signal   = (dir_of(state_q) == DIR_LEFT) || (dir_of(state_q) == DIR_RIGHT);

  always_comb begin
    hold_d  = hold_q;
    flash_d = flash_q;
    led_d   = 2'b00;
    if (lever_entry) begin
      hold_d  = '0;
      flash_d = '0;
    end else begin
      if ((state_d == state_q) && ((state_q == S_LEFT) || (state_q == S_RIGHT)) &&
          (hold_q != HW'(TAP_CYC)))
        hold_d = hold_q + 1'b1;
      if (in_signal && run && !restart && wrap && (flash_q != FW'(COMFORT_FLASHES)))
        flash_d = flash_q + 1'b1;
    end
    case (state_d)
      S_STEADY:              led_d = {STEADY_LIT, STEADY_LIT};
      S_LEFT, S_COMFORT_L:   led_d[LED_L] = lit;
      S_RIGHT, S_COMFORT_R:  led_d[LED_R] = lit;
      S_HAZARD:              led_d = {lit, lit};
      default:               led_d = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_OFF;
      hold_q  <= '0;
      flash_q <= '0;
      led_q   <= 2'b00;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      flash_q <= flash_d;
      led_q   <= led_d;
      done_q  <= done_d;
    end
  end

  assign bus.led          = led_q;
  assign bus.mode         = state_q;
  assign bus.comfort_done = done_q;
endmodule

// File: tb/tb_turn_signal_seq.sv
// Directed bench for turn_signal_seq: a single-cycle vector table plus
// hand-written multi-cycle sequences (long hold, taps, interruptions, reset).
module tb_turn_signal_seq;
  localparam logic [2:0] M_OFF = 3'd0, M_STEADY = 3'd1, M_LEFT = 3'd2, M_RIGHT = 3'd3;
  localparam logic [2:0] M_HAZARD = 3'd4, M_CL = 3'd5, M_CR = 3'd6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  turn_signal_seq_if bus1 ();
  turn_signal_seq_if bus0 ();

  turn_signal_seq #(
    .PERIOD_CYC(10), .ON_CYC(4), .TAP_CYC(8), .COMFORT_FLASHES(3), .STEADY_ON(1)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1.slave)
  );

  turn_signal_seq #(
    .PERIOD_CYC(10), .ON_CYC(4), .TAP_CYC(8), .COMFORT_FLASHES(3), .STEADY_ON(0)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0.slave)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       p, l, r, h;
    logic [1:0] led1;
    logic [1:0] led0;
    logic [2:0] mode;
  } vec_t;

  vec_t tbl [12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic p, input logic l, input logic r, input logic h);
    bus1.power = p; bus1.left = l; bus1.right = r; bus1.hazard = h;
    bus0.power = p; bus0.left = l; bus0.right = r; bus0.hazard = h;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk3(input string tag, input logic [1:0] el, input logic [2:0] em,
                      input logic ed);
    chk({tag, "_led"},  {6'd0, bus1.led}, {6'd0, el});
    chk({tag, "_mode"}, {5'd0, bus1.mode}, {5'd0, em});
    chk({tag, "_done"}, {7'd0, bus1.comfort_done}, {7'd0, ed});
  endtask

  // Full comfort sequence from STEADY: 3-cycle tap, three 4-cycle flashes, done at 30.
  task automatic tap_seq(input logic is_left, input string tag);
    int         windows;
    logic       prev, cur;
    logic [1:0] el;
    logic [2:0] em;
    windows = 0;
    prev    = 1'b0;
    for (int i = 0; i <= 31; i++) begin
      drive(1'b1, is_left && (i < 3), !is_left && (i < 3), 1'b0);
      tick();
      if (i < 30) begin
        el = ((i % 10) < 4) ? (is_left ? 2'b10 : 2'b01) : 2'b00;
        em = (i < 3) ? (is_left ? M_LEFT : M_RIGHT) : (is_left ? M_CL : M_CR);
        chk3($sformatf("%s_c%0d", tag, i), el, em, 1'b0);
        cur = is_left ? bus1.led[1] : bus1.led[0];
        if (cur && !prev) windows++;
        prev = cur;
      end else if (i == 30) begin
        chk3($sformatf("%s_end", tag), 2'b11, M_STEADY, 1'b1);
      end else begin
        chk3($sformatf("%s_after", tag), 2'b11, M_STEADY, 1'b0);
      end
    end
    chk({tag, "_windows"}, 8'(windows), 8'd3);
  endtask

  initial begin
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, M_OFF};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 2'b00, M_STEADY};
    tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b0, 2'b11, 2'b00, M_STEADY};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 2'b10, M_LEFT};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 2'b10, M_LEFT};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 2'b11, 2'b11, M_HAZARD};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 2'b11, 2'b11, M_HAZARD};
    tbl[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 2'b01, 2'b01, M_RIGHT};
    tbl[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 2'b11, 2'b00, M_STEADY};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, M_OFF};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b1, 2'b11, 2'b11, M_HAZARD};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 2'b00, M_STEADY};

    // Reset held with a lever pressed, then a long hold and release
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk3($sformatf("rst%0d", i), 2'b00, M_OFF, 1'b0);
      chk($sformatf("rst%0d_led0", i), {6'd0, bus0.led}, 8'd0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      chk3($sformatf("hold%0d", i), ((i % 10) < 4) ? 2'b10 : 2'b00, M_LEFT, 1'b0);
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    chk3("hold_rel", 2'b11, M_STEADY, 1'b0);

    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].p, tbl[i].l, tbl[i].r, tbl[i].h);
      tick();
      chk3($sformatf("tbl%0d", i), tbl[i].led1, tbl[i].mode, 1'b0);
      chk($sformatf("tbl%0d_led0", i), {6'd0, bus0.led}, {6'd0, tbl[i].led0});
    end

    tap_seq(1'b0, "tapR");

    // Hazard interrupts a left comfort sequence during its second flash
    for (int i = 0; i < 26; i++) begin
      drive(1'b1, i < 3, 1'b0, i >= 12);
      tick();
      if (i < 12)
        chk3($sformatf("hz_c%0d", i), ((i % 10) < 4) ? 2'b10 : 2'b00,
             (i < 3) ? M_LEFT : M_CL, 1'b0);
      else
        chk3($sformatf("hz_h%0d", i), (((i - 12) % 10) < 4) ? 2'b11 : 2'b00,
             M_HAZARD, 1'b0);
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    chk3("hz_rel", 2'b11, M_STEADY, 1'b0);

    // Tap boundary (8 held edges = tap, 9 = long), same-side re-press, opposite lever
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b0);
      tick();
      chk3($sformatf("bd_r%0d", i), (i < 4) ? 2'b01 : 2'b00, M_RIGHT, 1'b0);
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    chk3("bd_tap8", 2'b00, M_CR, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    chk3("bd_repress", 2'b00, M_RIGHT, 1'b0);
    tick();
    chk3("bd_repress_wrap", 2'b01, M_RIGHT, 1'b0);
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0);
      tick();
      chk3($sformatf("bd_l%0d", i), (i < 4) ? 2'b10 : 2'b00, M_LEFT, 1'b0);
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    chk3("bd_long9", 2'b11, M_STEADY, 1'b0);

    // Reset during the second flash of a comfort sequence, then a fresh tap
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, i < 3, 1'b0, 1'b0);
      if (i == 11) rst_n = 1'b0;
      tick();
      if (i < 11)
        chk3($sformatf("mr_c%0d", i), ((i % 10) < 4) ? 2'b10 : 2'b00,
             (i < 3) ? M_LEFT : M_CL, 1'b0);
      else
        chk3("mr_rst", 2'b00, M_OFF, 1'b0);
    end
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    chk3("mr_steady", 2'b11, M_STEADY, 1'b0);
    tap_seq(1'b1, "tapL");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
